// File: rtl/serial_alu_driver.sv
// serial_alu_driver
//
// Bit-serial initiator for a 1-bit ALU slice. It latches two WIDTH-bit
// operands and an operation code on start. It then feeds the operands into
// one external ALU slice, one bit per cycle and LSB first. The returned bits
// are collected into a WIDTH-bit result.
//
// Optional feature macro: SERIAL_ALU_DRIVER_CHECK_EN
//   When this macro is defined, an internal reference checks every returned
//   slice bit and sets a sticky err_o flag on the first mismatch.
//   When it is not defined, err_o is tied to 0 and no checking logic is built.
//
// Ports
//   clk_i        clock; all state changes on its rising edge
//   rst_ni       synchronous active-low reset
//   start_i      operation request; sampled only while idle
//   m_i          mode bit; latched and forwarded to the slice unchanged
//   s1_i, s0_i   operation select; latched on start
//   a_i, b_i     WIDTH-bit operands; latched on start
//   busy_o       high while an operation is running or completing
//   done_o       one-cycle pulse in the cycle after f_o is updated
//   f_o          result register; holds its value until the next completion
//   err_o        sticky slice-mismatch flag (see macro above)
//   slice_*_o    drive to the ALU slice; all zero outside RUN
//   slice_f_i    slice result, combinational response to slice_*_o
module serial_alu_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             m_i,
  input  logic             s1_i,
  input  logic             s0_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] f_o,
  output logic             err_o,
  output logic             slice_m_o,
  output logic             slice_s1_o,
  output logic             slice_s0_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  input  logic             slice_f_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // The shift register keeps only the upper WIDTH-1 result bits. The bit
  // that would fall off the bottom is never part of the final result.
  logic [WIDTH-2:0] r_sh_q, r_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_q, m_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             run;

  // All datapath and control registers live here. A low reset clears
  // everything, including a partially completed operation, so an aborted
  // operation never produces a done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      m_q     <= 1'b0;
      s_q     <= 2'b00;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      s_q     <= s_d;
      f_q     <= f_d;
    end
  end

  // Next-state logic. In RUN, the operand registers shift right one bit per
  // cycle. The returned slice bit enters the result register at its MSB, so
  // after WIDTH cycles the first (LSB) result bit has reached bit 0. The
  // counter holds at its last value rather than wrapping.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    s_d     = s_q;
    f_d     = f_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          m_d     = m_i;
          s_d     = {s1_i, s0_i};
          cnt_d   = '0;
          r_sh_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = (WIDTH-1)'({slice_f_i, r_sh_q} >> 1);
        if (cnt_q == LastBit) begin
          f_d     = {slice_f_i, r_sh_q};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs are decoded from registered state only. The slice drive is
  // gated to zero outside RUN.
  always_comb begin
    run        = (state_q == RUN);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    f_o        = f_q;
    slice_m_o  = run & m_q;
    slice_s1_o = run & s_q[1];
    slice_s0_o = run & s_q[0];
    slice_a_o  = run & a_sh_q[0];
    slice_b_o  = run & b_sh_q[0];
  end

`ifdef SERIAL_ALU_DRIVER_CHECK_EN
  logic err_q, err_d;
  logic exp_bit;

  // Reference slice: 00 passes A, 01 inverts A, 10 is XOR, 11 is XNOR.
  // Any disagreement during RUN latches err until reset.
  always_comb begin
    case ({slice_s1_o, slice_s0_o})
      2'b00:   exp_bit = slice_a_o;
      2'b01:   exp_bit = ~slice_a_o;
      2'b10:   exp_bit = slice_a_o ^ slice_b_o;
      default: exp_bit = ~(slice_a_o ^ slice_b_o);
    endcase
    err_d = err_q | (run & (exp_bit != slice_f_i));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_driver.sv
// tb_serial_alu_driver
//
// Testbench for serial_alu_driver with WIDTH=8. A behavioural 1-bit ALU slice
// is attached to the slice ports, with an optional single-bit fault injector.
// Results are compared against word-level arithmetic on the operands.
module tb_serial_alu_driver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstN;
  logic             startI;
  logic             mI, s1I, s0I;
  logic [WIDTH-1:0] aI, bI;
  logic             busyO, doneO, errO;
  logic [WIDTH-1:0] fO;
  logic             sliceM, sliceS1, sliceS0, sliceA, sliceB, sliceF;
  logic             modelBit;
  logic             injectNow = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [1:0]       s;
    logic [WIDTH-1:0] f;
  } vec_t;

  vec_t vecTable[4];

  always #5 clk = ~clk;

  serial_alu_driver #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .start_i    (startI),
    .m_i        (mI),
    .s1_i       (s1I),
    .s0_i       (s0I),
    .a_i        (aI),
    .b_i        (bI),
    .busy_o     (busyO),
    .done_o     (doneO),
    .f_o        (fO),
    .err_o      (errO),
    .slice_m_o  (sliceM),
    .slice_s1_o (sliceS1),
    .slice_s0_o (sliceS0),
    .slice_a_o  (sliceA),
    .slice_b_o  (sliceB),
    .slice_f_i  (sliceF)
  );

  // External 1-bit ALU slice, with an optional forced inversion of its output.
  always_comb begin
    case ({sliceS1, sliceS0})
      2'b00:   modelBit = sliceA;
      2'b01:   modelBit = ~sliceA;
      2'b10:   modelBit = sliceA ^ sliceB;
      default: modelBit = ~(sliceA ^ sliceB);
    endcase
    sliceF = modelBit ^ injectNow;
  end

  // Word-level reference for the whole operation.
  function automatic logic [WIDTH-1:0] refAlu(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0] s);
    case (s)
      2'b00:   return a;
      2'b01:   return ~a;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses start for one cycle and returns at the negedge of RUN cycle 0.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic m, input logic [1:0] s);
    @(negedge clk);
    startI = 1'b1;
    aI = a;
    bI = b;
    mI = m;
    {s1I, s0I} = s;
    @(negedge clk);
    startI = 1'b0;
    aI = '0;
    bI = '0;
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic m, input logic [1:0] s,
                       input logic [WIDTH-1:0] expF, input string name);
    logic [WIDTH-1:0] fBefore;
    int doneAt;
    int doneCount;
    int busyCount;
    int fChanged;
    int mBad;
    fBefore = fO;
    doneAt = -1;
    doneCount = 0;
    busyCount = 0;
    fChanged = 0;
    mBad = 0;
    applyStimulus(a, b, m, s);
    for (int k = 0; k < WIDTH + 6; k++) begin
      if (k > 0) @(negedge clk);
      if (busyO) busyCount++;
      if (doneO) begin
        doneCount++;
        if (doneAt < 0) doneAt = k;
      end
      if (busyO && !doneO && fO !== fBefore) fChanged++;
      if (busyO && !doneO && sliceM !== m) mBad++;
    end
    checkOutput({name, " done latency"}, doneAt, WIDTH);
    checkOutput({name, " done count"}, doneCount, 1);
    checkOutput({name, " busy cycles"}, busyCount, WIDTH + 1);
    checkOutput({name, " F"}, fO, expF);
    checkOutput({name, " F stable in RUN"}, fChanged, 0);
    checkOutput({name, " slice_M forwarded"}, mBad, 0);
    checkOutput({name, " idle after"}, busyO, 0);
  endtask

  initial begin
    int doneCount;
    logic [WIDTH-1:0] ra, rb;
    logic [1:0] rs;
    logic rm;

    vecTable[0] = '{a: 8'hA5, b: 8'h00, m: 1'b0, s: 2'b00, f: 8'hA5};
    vecTable[1] = '{a: 8'h3C, b: 8'h00, m: 1'b1, s: 2'b01, f: 8'hC3};
    vecTable[2] = '{a: 8'hF0, b: 8'hAA, m: 1'b0, s: 2'b10, f: 8'h5A};
    vecTable[3] = '{a: 8'hF0, b: 8'hAA, m: 1'b1, s: 2'b11, f: 8'hA5};

    rstN = 1'b0;
    startI = 1'b0;
    mI = 1'b0;
    s1I = 1'b0;
    s0I = 1'b0;
    aI = '0;
    bI = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busyO, 0);
    checkOutput("reset done", doneO, 0);
    checkOutput("reset F", fO, 0);
    checkOutput("reset err", errO, 0);
    checkOutput("reset slice", {sliceM, sliceS1, sliceS0, sliceA, sliceB}, 0);
    rstN = 1'b1;

    for (int i = 0; i < 4; i++)
      runOp(vecTable[i].a, vecTable[i].b, vecTable[i].m, vecTable[i].s,
            vecTable[i].f, $sformatf("table%0d", i));

    // Start pulses during RUN and during DONE must be ignored.
    applyStimulus(8'h01, 8'h00, 1'b0, 2'b00);
    doneCount = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (doneO) doneCount++;
      if (k == 3 || k == 8) begin
        startI = 1'b1;
        aI = 8'hFF;
      end else begin
        startI = 1'b0;
        aI = '0;
      end
    end
    checkOutput("ignored start done count", doneCount, 1);
    checkOutput("ignored start F", fO, 8'h01);
    checkOutput("ignored start idle", busyO, 0);

    // A reset in the middle of RUN aborts the operation without a done pulse.
    runOp(8'h12, 8'h00, 1'b0, 2'b00, 8'h12, "preload");
    applyStimulus(8'hFF, 8'h00, 1'b1, 2'b00);
    repeat (4) @(negedge clk);
    checkOutput("abort F held", fO, 8'h12);
    checkOutput("abort busy in RUN", busyO, 1);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", busyO, 0);
    checkOutput("abort done", doneO, 0);
    checkOutput("abort F", fO, 0);
    checkOutput("abort slice", {sliceM, sliceS1, sliceS0, sliceA, sliceB}, 0);
    rstN = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (doneO) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    runOp(8'h5A, 8'h00, 1'b0, 2'b00, 8'h5A, "after abort");

`ifdef SERIAL_ALU_DRIVER_CHECK_EN
    // Invert the slice output for bit 3 only. err must rise at the next edge
    // and stay set until reset.
    applyStimulus(8'h00, 8'h00, 1'b0, 2'b00);
    repeat (3) @(negedge clk);
    checkOutput("err before fault", errO, 0);
    injectNow = 1'b1;
    @(negedge clk);
    injectNow = 1'b0;
    checkOutput("err after fault", errO, 1);
    repeat (8) @(negedge clk);
    checkOutput("faulty F", fO, 8'h08);
    runOp(8'h3C, 8'h00, 1'b0, 2'b00, 8'h3C, "clean after fault");
    checkOutput("err sticky", errO, 1);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("err cleared by reset", errO, 0);
`endif

    // Randomised operations against the word-level reference.
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 2'($urandom_range(0, 3));
      rm = 1'($urandom_range(0, 1));
      runOp(ra, rb, rm, rs, refAlu(ra, rb, rs), $sformatf("rand%0d", i));
    end
    checkOutput("err quiet with correct slice", errO, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_alu_driver.md
# serial_alu_driver

Bit-serial initiator for the 1-bit ALU slice interface (M, S1, S0, A, B -> F). It accepts WIDTH-bit operands and an operation code, then drives them into an external 1-bit ALU slice one bit per cycle, LSB first. It assembles the returned F bits into a WIDTH-bit result and reports completion with a busy/done handshake. It sits between the datapath control and a single ALU slice, so one slice can serve multi-bit operations.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is 2..32.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- M  in  1  mode bit; latched on start and forwarded to the slice unchanged.
- S1, S0  in  1 each  operation select; latched on start.
- A, B  in  WIDTH each  operands; latched on start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when F is updated.
- F  out  WIDTH  result register.
- err  out  1  sticky slice-mismatch flag; see Configuration.
- slice_M, slice_S1, slice_S0, slice_A, slice_B  out  1 each  drive to the ALU slice.
- slice_F  in  1  slice result; combinational response to the slice_* outputs in the same cycle.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: latch A, B, M, S1, S0 into a_sh, b_sh, m_r, s_r; clear the bit counter cnt and the shift register r_sh; go to RUN.
- RUN:
  - Drive slice_A=a_sh[0], slice_B=b_sh[0], slice_M=m_r, {slice_S1,slice_S0}=s_r.
  - Each cycle: a_sh and b_sh shift right by 1; r_sh <= {slice_F, r_sh[WIDTH-1:1]}; cnt increments.
  - When cnt==WIDTH-1, go to DONE and load F <= {slice_F, r_sh[WIDTH-1:1]}.
- DONE:
  - done=1 for exactly this one cycle, then go to IDLE.
  - start is ignored here.
- Outside RUN, all slice_* outputs are 0.
- start is ignored in RUN and DONE; there is no queueing.
- F holds its value until the next completion; it does not change during RUN.
- cnt is ceil(log2(WIDTH)) bits wide and never wraps within an operation.
- Reset (rst_n=0 at a clock edge), including mid-RUN:
  - state=IDLE; busy=0, done=0, F=0, err=0; all slice_* = 0; a_sh, b_sh, r_sh, cnt cleared.
  - The aborted operation produces no done.

## Timing
- Start accepted at edge 0 (state IDLE, start=1).
- RUN occupies the cycles after edges 0..WIDTH-1; bit i is driven in the cycle after edge i.
- F is loaded and DONE entered at edge WIDTH; done is high for the cycle after edge WIDTH.
- Back in IDLE after edge WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- Latency from start to done is WIDTH+1 cycles; for WIDTH=8, done is high in the 9th cycle after the start edge.
- No combinational path from any input to any output except slice_F -> nothing (slice_F is only registered).

## Configuration
- SERIAL_ALU_DRIVER_CHECK_EN defined:
  - An internal model computes the expected bit each RUN cycle: S=00 gives A; 01 gives ~A; 10 gives A^B; 11 gives ~(A^B), using slice_A/slice_B.
  - Any mismatch with slice_F sets err=1 at the next edge.
  - err stays 1 until reset.
- Not defined: err is constant 0 and no model logic is built.

## Test plan
- WIDTH=8, slice model attached; A=8'hA5, S=00, start one cycle -> busy high for 9 cycles, done pulse 9 cycles after start, F=8'hA5.
- A=8'h3C, S=01 -> F=8'hC3. Then A=8'hF0, B=8'hAA, S=10 -> F=8'h5A. Same operands, S=11 -> F=8'hA5.
- Start A=8'h01, S=00; pulse start with A=8'hFF in RUN cycle 3 and again in the DONE cycle -> only one done, F=8'h01, state IDLE afterwards.
- Start A=8'hFF, S=00 after F=8'h12 is held; assert rst_n=0 in RUN cycle 4 -> next edge busy=0, F=8'h00, slice_* = 0, no done; a new start then completes normally.
- SERIAL_ALU_DRIVER_CHECK_EN defined: slice model inverts the bit in RUN cycle 3; A=8'h00, S=00 -> err=1 from the following edge, F=8'h08; err stays 1 across a subsequent clean operation until rst_n=0.
